axi_rd_arbiter: RTL

Read-channel arbiter that shares the single AXI read address/data channel (AR/R) between the instruction-fetch requester and the data-access requester of the pipelined CPU. It accepts SRAM-style requests (req / addr_ok / data_ok) and chooses one per grant with fixed priority to data. It issues single-beat AXI reads tagged by requester ID, tracks outstanding reads per ID, and routes R-channel responses back by `rid`. It also holds a data read while a pending write targets the same word, which prevents read-after-write hazards through the bus.

---
 rtl/axi_rd_arbiter_if.sv | 69 ++++++
 rtl/axi_rd_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - bundle of requester, write-hazard and AXI AR/R signals for axi_rd_arbiter
//
// Groups every signal of the read arbiter except clk/reset.
//   inst_*  : instruction-fetch SRAM-style request/response
//   data_*  : data-access SRAM-style request/response (reads only)
//   wr_*    : pending-write indication used for the read-after-write hold
//   ar*/r*  : AXI read address and read data channels
// Modports:
//   master : the arbiter (drives AR, rready, addr_ok/data_ok/rdata)
//   slave  : the environment (requesters, write side and AXI slave)

interface axi_rd_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        wr_busy;
  logic [31:0] wr_addr;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_req, inst_addr, inst_size,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_addr, data_size,
    output data_addr_ok, data_data_ok, data_rdata,
    input  wr_busy, wr_addr,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_addr, inst_size,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_addr, data_size,
    input  data_addr_ok, data_data_ok, data_rdata,
    output wr_busy, wr_addr,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI read channel between instruction fetch and data access
//
// Accepts SRAM-style read requests from two requesters, grants one at a time
// (data has fixed priority), issues single-beat AXI reads tagged with
// arid 0 (inst) / 1 (data) and routes R beats back by rid.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : axi_rd_arbiter_if.master (requesters, wr_busy/wr_addr, AR, R)
// Parameters:
//   MAX_OUT : outstanding reads allowed per requester ID
//   CNT_W   : width of each outstanding counter (must hold MAX_OUT)

module axi_rd_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  axi_rd_arbiter_if.master  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_inst;
  logic [CNT_W-1:0] cnt_data;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             id_q;
  logic             arvalid_q;
  logic             rready_q;

  logic raw_hazard;
  logic inst_elig;
  logic data_elig;
  logic grant_inst;
  logic grant_data;
  logic r_hs;
  logic rsp_inst;
  logic rsp_data;
  logic ar_hs;
  logic ar_inst;
  logic ar_data;

  // Only the word address matters for the hazard; byte lanes are ignored.
  logic unused_wr_lsb;
  assign unused_wr_lsb = ^bus.wr_addr[1:0];

  always_comb begin
    raw_hazard = bus.wr_busy && (bus.wr_addr[31:2] == bus.data_addr[31:2]);
    inst_elig  = bus.inst_req && (cnt_inst < CNT_W'(MAX_OUT));
    data_elig  = bus.data_req && (cnt_data < CNT_W'(MAX_OUT)) && !raw_hazard;
    grant_data = !reset && (state == IDLE) && data_elig;
    grant_inst = !reset && (state == IDLE) && !data_elig && inst_elig;
    // Beats for an unknown ID or an ID with nothing outstanding are consumed
    // (rready stays high) but never surface as data_ok.
    r_hs       = !reset && bus.rvalid && rready_q;
    rsp_inst   = r_hs && (bus.rid == 4'd0) && (cnt_inst != '0);
    rsp_data   = r_hs && (bus.rid == 4'd1) && (cnt_data != '0);
    ar_hs      = (state == ISSUE) && arvalid_q && bus.arready;
    ar_inst    = ar_hs && !id_q;
    ar_data    = ar_hs && id_q;
  end

  // Issue and retire on the same ID in one cycle cancel out.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                               input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + CNT_W'(1);
      2'b01:   return c - CNT_W'(1);
      default: return c;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_inst  <= '0;
      cnt_data  <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      id_q      <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      cnt_inst <= next_cnt(cnt_inst, ar_inst, rsp_inst);
      cnt_data <= next_cnt(cnt_data, ar_data, rsp_data);
      case (state)
        IDLE: begin
          if (grant_data || grant_inst) begin
            addr_q    <= grant_data ? bus.data_addr : bus.inst_addr;
            size_q    <= grant_data ? bus.data_size : bus.inst_size;
            id_q      <= grant_data;
            arvalid_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;
  assign bus.inst_data_ok = rsp_inst;
  assign bus.data_data_ok = rsp_data;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;

  assign bus.arid    = {3'b000, id_q};
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

endmodule
